// File: rtl/ex_alu_unit.sv
// rtl/ex_alu_unit.sv - execute-stage ALU with shift-add MULTU and HI/LO registers
module ex_alu_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [5:0]       funct,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    input  logic [4:0]       shamt,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic             out_zero,
    output logic             out_illegal
);

    localparam logic [5:0] F_ADD   = 6'b001001;
    localparam logic [5:0] F_SUB   = 6'b001010;
    localparam logic [5:0] F_SLL   = 6'b100001;
    localparam logic [5:0] F_OR    = 6'b100101;
    localparam logic [5:0] F_MULTU = 6'b011001;
    localparam logic [5:0] F_MFHI  = 6'b010000;
    localparam logic [5:0] F_MFLO  = 6'b010010;

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DONE} state_t;

    state_t             state, state_next;
    logic [4:0]         cnt;
    logic [WIDTH-1:0]   mcand;
    logic [2*WIDTH-1:0] acc;
    logic [WIDTH-1:0]   hi, lo;
    logic [WIDTH-1:0]   res;
    logic               illegal;
    logic               accept;
    logic               is_multu;
    logic [WIDTH:0]     sum;
    logic [2*WIDTH-1:0] acc_step;

    assign in_ready = (state == S_IDLE) && (!out_valid || out_ready);
    assign accept   = in_valid && in_ready;
    assign is_multu = (funct == F_MULTU);

    // Low accumulator half holds the remaining multiplier bits; the carry out
    // of the upper-half add is shifted back in so no product bit is lost.
    assign sum      = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, mcand} : '0);
    assign acc_step = {sum, acc[WIDTH-1:1]};

    always_comb begin
        res     = '0;
        illegal = 1'b0;
        case (funct)
            F_ADD:   res = src_a + src_b;
            F_SUB:   res = src_a - src_b;
            F_SLL:   res = src_b << shamt;
            F_OR:    res = src_a | src_b;
            F_MULTU: res = '0;
            F_MFHI:  res = hi;
            F_MFLO:  res = lo;
            default: illegal = 1'b1;
        endcase
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:  if (accept && is_multu) state_next = S_MUL;
            S_MUL:   if (cnt == 5'd31) state_next = S_DONE;
            S_DONE:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt   <= '0;
            mcand <= '0;
            acc   <= '0;
            hi    <= '0;
            lo    <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept && is_multu) begin
                        cnt   <= '0;
                        mcand <= src_a;
                        acc   <= {{WIDTH{1'b0}}, src_b};
                    end
                end
                S_MUL: begin
                    acc <= acc_step;
                    cnt <= cnt + 5'd1;
                end
                S_DONE: begin
                    hi <= acc[2*WIDTH-1:WIDTH];
                    lo <= acc[WIDTH-1:0];
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid   <= 1'b0;
            out_result  <= '0;
            out_zero    <= 1'b0;
            out_illegal <= 1'b0;
        end else if (state == S_DONE) begin
            out_valid   <= 1'b1;
            out_result  <= '0;
            out_zero    <= 1'b1;
            out_illegal <= 1'b0;
        end else if (accept && !is_multu) begin
            out_valid   <= 1'b1;
            out_result  <= res;
            out_zero    <= (res == '0);
            out_illegal <= illegal;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_ex_alu_unit.sv
// tb/tb_ex_alu_unit.sv - scoreboard bench for ex_alu_unit with randomized traffic
module tb_ex_alu_unit;

    localparam logic [5:0] F_ADD   = 6'b001001;
    localparam logic [5:0] F_SUB   = 6'b001010;
    localparam logic [5:0] F_SLL   = 6'b100001;
    localparam logic [5:0] F_OR    = 6'b100101;
    localparam logic [5:0] F_MULTU = 6'b011001;
    localparam logic [5:0] F_MFHI  = 6'b010000;
    localparam logic [5:0] F_MFLO  = 6'b010010;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [5:0]  funct;
    logic [31:0] src_a, src_b;
    logic [4:0]  shamt;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic        out_zero;
    logic        out_illegal;

    always #5 clk = ~clk;

    ex_alu_unit #(.WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .funct(funct), .src_a(src_a), .src_b(src_b), .shamt(shamt),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_zero(out_zero), .out_illegal(out_illegal)
    );

    int total = 0;
    int bad = 0;
    logic [33:0] exp_q[$];
    logic [31:0] hi_m, lo_m;
    logic        held_v;
    logic [33:0] held;
    bit          rand_done;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference: {illegal, zero, result} from the function-code table.
    function automatic logic [33:0] model(input logic [5:0] f, input logic [31:0] a,
                                          input logic [31:0] b, input logic [4:0] sh);
        logic [31:0] r;
        logic        ill;
        r = 32'd0;
        ill = 1'b0;
        case (f)
            F_ADD:   r = a + b;
            F_SUB:   r = a - b;
            F_SLL:   r = b << sh;
            F_OR:    r = a | b;
            F_MULTU: r = 32'd0;
            F_MFHI:  r = hi_m;
            F_MFLO:  r = lo_m;
            default: ill = 1'b1;
        endcase
        return {ill, (r == 32'd0), r};
    endfunction

    task automatic issue(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] sh, output int waited);
        logic [63:0] p;
        funct = f; src_a = a; src_b = b; shamt = sh;
        in_valid = 1'b1;
        waited = 0;
        @(negedge clk);
        while (!in_ready && waited < 200) begin
            waited++;
            @(negedge clk);
        end
        if (!in_ready) begin
            total++;
            bad++;
            $display("FAIL accept_timeout: funct %b not accepted in 200 cycles", f);
        end else begin
            exp_q.push_back(model(f, a, b, sh));
            if (f == F_MULTU) begin
                p = {32'd0, a} * {32'd0, b};
                hi_m = p[63:32];
                lo_m = p[31:0];
            end
        end
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            held_v = 1'b0;
        end else begin
            if (held_v && out_valid)
                chk("stall_hold", {30'd0, out_illegal, out_zero, out_result}, {30'd0, held});
            held_v = out_valid && !out_ready;
            held   = {out_illegal, out_zero, out_result};
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_output: got 0x%0h with empty scoreboard", out_result);
                end else begin
                    logic [33:0] e;
                    e = exp_q.pop_front();
                    chk("result", out_result, e[31:0]);
                    chk("zero", out_zero, e[32]);
                    chk("illegal", out_illegal, e[33]);
                end
            end
        end
    end

    initial begin
        int w, w2, cyc, low;
        logic [31:0] r0;
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        funct = '0; src_a = '0; src_b = '0; shamt = '0;
        hi_m = '0; lo_m = '0; held_v = 1'b0; held = '0; rand_done = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_result", out_result, 0);
        chk("rst_out_zero", out_zero, 0);
        chk("rst_out_illegal", out_illegal, 0);
        chk("rst_in_ready", in_ready, 1);
        @(posedge clk); #1;

        issue(F_ADD, 32'h7FFF_FFFF, 32'd1, 5'd0, w);
        chk("add_latency", out_valid, 1);
        issue(F_SUB, 32'd5, 32'd5, 5'd0, w);

        issue(F_SLL, 32'd0, 32'd1, 5'd31, w);
        issue(F_OR, 32'hF0F0_0000, 32'h0000_F0F0, 5'd0, w2);
        chk("b2b_wait_sll", w, 0);
        chk("b2b_wait_or", w2, 0);

        issue(F_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd0, w);
        cyc = 0; low = 0;
        while (!out_valid && cyc < 100) begin
            if (!in_ready) low++;
            @(posedge clk); #1;
            cyc++;
        end
        chk("multu_latency", cyc, 33);
        chk("multu_busy_cycles", low, 33);
        issue(F_MFHI, 32'd0, 32'd0, 5'd0, w);
        issue(F_MFLO, 32'd0, 32'd0, 5'd0, w);

        issue(F_ADD, 32'd10, 32'd20, 5'd0, w);
        out_ready = 1'b0;
        r0 = out_result;
        fork
            issue(F_OR, 32'h1, 32'h2, 5'd0, w);
            begin
                repeat (5) begin
                    @(negedge clk);
                    chk("stall_result", out_result, r0);
                    chk("stall_in_ready", in_ready, 0);
                end
                @(posedge clk); #1 out_ready = 1'b1;
            end
        join
        chk("stall_not_accepted", (w >= 5), 1);

        issue(6'b111111, 32'h1234, 32'h5678, 5'd3, w);
        issue(F_ADD, 32'd1, 32'd2, 5'd0, w);

        issue(F_MULTU, 32'd3, 32'd4, 5'd0, w);
        repeat (10) @(posedge clk);
        #1 rst_n = 1'b0;
        exp_q.delete();
        hi_m = '0; lo_m = '0;
        @(posedge clk); #1 rst_n = 1'b1;
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_out_result", out_result, 0);
        chk("midrst_out_zero", out_zero, 0);
        chk("midrst_out_illegal", out_illegal, 0);
        chk("midrst_in_ready", in_ready, 1);
        issue(F_MFLO, 32'd0, 32'd0, 5'd0, w);

        fork
            begin
                logic [5:0] codes [8];
                codes = '{F_ADD, F_SUB, F_SLL, F_OR, F_MULTU, F_MFHI, F_MFLO, 6'b000000};
                for (int i = 0; i < 150; i++) begin
                    logic [5:0] f;
                    f = codes[$urandom_range(0, 7)];
                    if (f == 6'b000000) f = 6'($urandom);
                    issue(f, $urandom, $urandom, 5'($urandom), w);
                end
                rand_done = 1'b1;
            end
            begin
                while (!rand_done) begin
                    @(posedge clk); #1 out_ready = 1'($urandom_range(0, 1));
                end
                out_ready = 1'b1;
            end
        join

        cyc = 0;
        while (exp_q.size() != 0 && cyc < 100) begin
            @(posedge clk);
            cyc++;
        end
        @(negedge clk);
        chk("drain_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
